// File: rtl/ysyx_22040365_pkg.sv
// Shared encodings for the writeback unit: result-source select, load size
// and the buffer occupancy states.
package ysyx_22040365_pkg;

  typedef enum logic [1:0] {
    WB_ALU  = 2'd0,
    WB_LOAD = 2'd1,
    WB_PC4  = 2'd2,
    WB_CSR  = 2'd3
  } wb_sel_e;

  typedef enum logic [1:0] {
    LD_B = 2'd0,
    LD_H = 2'd1,
    LD_W = 2'd2,
    LD_D = 2'd3
  } ld_size_e;

  localparam logic [0:0] S_EMPTY = 1'b0;
  localparam logic [0:0] S_FULL  = 1'b1;

endpackage

// File: rtl/ysyx_22040365_load_ext.sv
// Combinational load-data extension: takes the low byte/half/word of the raw
// load data and sign- or zero-extends it to the datapath width.
module ysyx_22040365_load_ext
  import ysyx_22040365_pkg::*;
#(
  parameter int DATA_WIDTH = 64
) (
  input  logic [DATA_WIDTH-1:0] data,
  input  logic [1:0]            size,
  input  logic                  is_unsigned,
  output logic [DATA_WIDTH-1:0] result
);

  logic fill_b;
  logic fill_h;
  logic fill_w;

  assign fill_b = !is_unsigned && data[7];
  assign fill_h = !is_unsigned && data[15];
  assign fill_w = !is_unsigned && data[31];

  always_comb begin
    // NOTE: assign a default before the case so no path leaves result unassigned (no latch).
    result = data;
    case (ld_size_e'(size))
      LD_B:    result = {{(DATA_WIDTH-8){fill_b}},  data[7:0]};
      LD_H:    result = {{(DATA_WIDTH-16){fill_h}}, data[15:0]};
      LD_W:    result = {{(DATA_WIDTH-32){fill_w}}, data[31:0]};
      default: result = data;
    endcase
  end

endmodule

// File: rtl/ysyx_22040365_wbu.sv
// Writeback unit: one-entry result buffer feeding the register file write port,
// a decode bypass and a retire counter. Define YSYX_22040365_DIFFTEST_EN to add
// the commit_* trace outputs.
module ysyx_22040365_wbu
  import ysyx_22040365_pkg::*;
#(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ADDR_WIDTH-1:0] in_rd,
  input  logic                  in_rd_wen,
  input  logic [1:0]            in_wb_sel,
  input  logic [DATA_WIDTH-1:0] in_alu_res,
  input  logic [DATA_WIDTH-1:0] in_load_data,
  input  logic [DATA_WIDTH-1:0] in_csr_data,
  input  logic [1:0]            in_ld_size,
  input  logic                  in_ld_unsigned,
  input  logic [DATA_WIDTH-1:0] in_pc,
  input  logic                  halt,
  output logic                  rf_wen,
  output logic [ADDR_WIDTH-1:0] rf_waddr,
  output logic [DATA_WIDTH-1:0] rf_wdata,
  output logic                  fwd_valid,
  output logic [ADDR_WIDTH-1:0] fwd_rd,
  output logic [DATA_WIDTH-1:0] fwd_data,
`ifdef YSYX_22040365_DIFFTEST_EN
  output logic [63:0]           retire_cnt,
  output logic                  commit_valid,
  output logic [DATA_WIDTH-1:0] commit_pc,
  output logic                  commit_rd_wen,
  output logic [ADDR_WIDTH-1:0] commit_rd,
  output logic [DATA_WIDTH-1:0] commit_data
`else
  output logic [63:0]           retire_cnt
`endif
);

  logic [0:0]            state_q;
  logic                  rd_wen_q;
  logic [ADDR_WIDTH-1:0] rd_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [63:0]           cnt_q;

  logic                  full;
  logic                  retire;
  logic                  fire;
  logic                  writes_reg;
  logic [DATA_WIDTH-1:0] load_ext_data;
  logic [DATA_WIDTH-1:0] final_data;

  assign full       = (state_q == S_FULL);
  assign retire     = full && !halt && !rst;
  assign in_ready   = !rst && (!full || !halt);
  assign fire       = in_valid && in_ready;
  assign writes_reg = full && rd_wen_q && (rd_q != '0);

  ysyx_22040365_load_ext #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_load_ext (
    .data        (in_load_data),
    .size        (in_ld_size),
    .is_unsigned (in_ld_unsigned),
    .result      (load_ext_data)
  );

  always_comb begin
    final_data = in_alu_res;
    case (wb_sel_e'(in_wb_sel))
      WB_ALU:  final_data = in_alu_res;
      WB_LOAD: final_data = load_ext_data;
      WB_PC4:  final_data = in_pc + DATA_WIDTH'(4);
      WB_CSR:  final_data = in_csr_data;
      default: final_data = in_alu_res;
    endcase
  end

  // An accept in the same cycle as a retire simply overwrites the drained entry.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    if (rst) begin
      state_q  <= S_EMPTY;
      rd_wen_q <= 1'b0;
      rd_q     <= '0;
      data_q   <= '0;
      cnt_q    <= '0;
    end else begin
      if (retire) cnt_q <= cnt_q + 64'd1;
      if (fire) begin
        state_q  <= S_FULL;
        rd_wen_q <= in_rd_wen;
        rd_q     <= in_rd;
        data_q   <= final_data;
      end else if (retire) begin
        state_q  <= S_EMPTY;
        rd_wen_q <= 1'b0;
        rd_q     <= '0;
        data_q   <= '0;
      end
    end
  end

  assign rf_wen     = retire && rd_wen_q && (rd_q != '0);
  assign rf_waddr   = full ? rd_q   : '0;
  assign rf_wdata   = full ? data_q : '0;
  assign fwd_valid  = !rst && writes_reg;
  assign fwd_rd     = rf_waddr;
  assign fwd_data   = rf_wdata;
  assign retire_cnt = cnt_q;

`ifdef YSYX_22040365_DIFFTEST_EN
  logic [DATA_WIDTH-1:0] pc_q;

  always_ff @(posedge clk) begin
    if (rst)       pc_q <= '0;
    else if (fire) pc_q <= in_pc;
    else if (retire) pc_q <= '0;
  end

  assign commit_valid  = retire;
  assign commit_pc     = full ? pc_q : '0;
  assign commit_rd_wen = full && rd_wen_q;
  assign commit_rd     = rf_waddr;
  assign commit_data   = rf_wdata;
`endif

endmodule

// File: tb/tb_ysyx_22040365_wbu.sv
// Scoreboard bench for ysyx_22040365_wbu: stimulus pushes expected register
// writes into a queue, a negedge monitor pops and compares each rf_wen.
module tb_ysyx_22040365_wbu;
  import ysyx_22040365_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rd;
  logic        in_rd_wen;
  logic [1:0]  in_wb_sel;
  logic [63:0] in_alu_res;
  logic [63:0] in_load_data;
  logic [63:0] in_csr_data;
  logic [1:0]  in_ld_size;
  logic        in_ld_unsigned;
  logic [63:0] in_pc;
  logic        halt;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [63:0] rf_wdata;
  logic        fwd_valid;
  logic [4:0]  fwd_rd;
  logic [63:0] fwd_data;
  logic [63:0] retire_cnt;
`ifdef YSYX_22040365_DIFFTEST_EN
  logic        commit_valid;
  logic [63:0] commit_pc;
  logic        commit_rd_wen;
  logic [4:0]  commit_rd;
  logic [63:0] commit_data;
`endif

  always #5 clk = ~clk;

  ysyx_22040365_wbu dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_rd          (in_rd),
    .in_rd_wen      (in_rd_wen),
    .in_wb_sel      (in_wb_sel),
    .in_alu_res     (in_alu_res),
    .in_load_data   (in_load_data),
    .in_csr_data    (in_csr_data),
    .in_ld_size     (in_ld_size),
    .in_ld_unsigned (in_ld_unsigned),
    .in_pc          (in_pc),
    .halt           (halt),
    .rf_wen         (rf_wen),
    .rf_waddr       (rf_waddr),
    .rf_wdata       (rf_wdata),
    .fwd_valid      (fwd_valid),
    .fwd_rd         (fwd_rd),
    .fwd_data       (fwd_data),
`ifdef YSYX_22040365_DIFFTEST_EN
    .retire_cnt     (retire_cnt),
    .commit_valid   (commit_valid),
    .commit_pc      (commit_pc),
    .commit_rd_wen  (commit_rd_wen),
    .commit_rd      (commit_rd),
    .commit_data    (commit_data)
`else
    .retire_cnt     (retire_cnt)
`endif
  );

  typedef struct {
    logic [4:0]  rd;
    logic [63:0] data;
  } wr_t;

  wr_t         exp_q[$];
  int          n_checks = 0;
  int          n_pass = 0;
  logic [63:0] exp_retire = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one transaction; it is accepted at the next rising edge.
  task automatic set_in(input logic [4:0] rd, input logic [1:0] sel, input logic [63:0] alu,
                        input logic [63:0] ld, input logic [63:0] csr, input logic [1:0] sz,
                        input logic uns, input logic [63:0] pc);
    in_valid       = 1'b1;
    in_rd          = rd;
    in_rd_wen      = 1'b1;
    in_wb_sel      = sel;
    in_alu_res     = alu;
    in_load_data   = ld;
    in_csr_data    = csr;
    in_ld_size     = sz;
    in_ld_unsigned = uns;
    in_pc          = pc;
    exp_retire     = exp_retire + 1;
  endtask

  task automatic expect_wr(input logic [4:0] rd, input logic [63:0] data);
    wr_t e;
    e.rd   = rd;
    e.data = data;
    exp_q.push_back(e);
  endtask

  // Monitor: every register-file write must match the oldest expectation.
  always @(negedge clk) begin
    if (rf_wen) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_write: got rd=%0d data=0x%h expected no write", rf_waddr, rf_wdata);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("wr_addr", 64'(rf_waddr), 64'(e.rd));
        check("wr_data", rf_wdata, e.data);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; halt = 1'b0;
    in_rd = '0; in_rd_wen = 1'b0; in_wb_sel = '0; in_alu_res = '0; in_load_data = '0;
    in_csr_data = '0; in_ld_size = '0; in_ld_unsigned = 1'b0; in_pc = '0;

    // Reset state
    step();
    @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 0);
    check("rst_rf_wen", 64'(rf_wen), 0);
    check("rst_fwd_valid", 64'(fwd_valid), 0);
    check("rst_retire_cnt", retire_cnt, 0);
    step();
    rst = 1'b0;
    @(negedge clk);
    check("idle_in_ready", 64'(in_ready), 1);
    check("idle_waddr", 64'(rf_waddr), 0);
    check("idle_wdata", rf_wdata, 0);
    step();

    // ALU result to x5
    set_in(5, WB_ALU, 64'h1234, 0, 0, 0, 0, 0); expect_wr(5, 64'h1234);
    step();
    in_valid = 1'b0;
    @(negedge clk);
    check("alu_rf_wen", 64'(rf_wen), 1);
    check("alu_fwd_valid", 64'(fwd_valid), 1);
    check("alu_fwd_rd", 64'(fwd_rd), 5);
    check("alu_fwd_data", fwd_data, 64'h1234);
    step();
    check("alu_retire_cnt", retire_cnt, 1);
    check("alu_drained_wen", 64'(rf_wen), 0);

    // Load extension, back to back
    set_in(6, WB_LOAD, 0, 64'h80, 0, LD_B, 0, 0);               expect_wr(6, 64'hFFFF_FFFF_FFFF_FF80);
    step();
    set_in(7, WB_LOAD, 0, 64'h80, 0, LD_B, 1, 0);               expect_wr(7, 64'h80);
    step();
    set_in(8, WB_LOAD, 0, 64'h8000_0000, 0, LD_W, 0, 0);        expect_wr(8, 64'hFFFF_FFFF_8000_0000);
    step();
    set_in(9, WB_LOAD, 0, 64'h1234_5678_9ABC_8001, 0, LD_H, 0, 0); expect_wr(9, 64'hFFFF_FFFF_FFFF_8001);
    step();
    set_in(10, WB_LOAD, 0, 64'hDEAD_BEEF_8000_0001, 0, LD_W, 1, 0); expect_wr(10, 64'h8000_0001);
    step();
    set_in(11, WB_LOAD, 0, 64'h8123_4567_89AB_CDEF, 0, LD_D, 0, 0); expect_wr(11, 64'h8123_4567_89AB_CDEF);
    step();
    set_in(12, WB_LOAD, 0, 64'h1234_5678_0000_007F, 0, LD_B, 0, 0); expect_wr(12, 64'h7F);
    step();
    set_in(13, WB_CSR, 64'h1, 0, 64'hCAFE, 0, 0, 0);            expect_wr(13, 64'hCAFE);
    step();
    in_valid = 1'b0;
    step();
    check("load_retire_cnt", retire_cnt, exp_retire);

    // Write to x0 retires silently
    set_in(0, WB_ALU, 64'hDEAD, 0, 0, 0, 0, 0);
    step();
    in_valid = 1'b0;
    @(negedge clk);
    check("x0_rf_wen", 64'(rf_wen), 0);
    check("x0_fwd_valid", 64'(fwd_valid), 0);
    step();
    check("x0_retire_cnt", retire_cnt, exp_retire);

    // Halt holds the entry for three cycles
    set_in(14, WB_ALU, 64'h55, 0, 0, 0, 0, 0); expect_wr(14, 64'h55);
    step();
    in_valid = 1'b0;
    halt = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("halt_in_ready", 64'(in_ready), 0);
      check("halt_rf_wen", 64'(rf_wen), 0);
      check("halt_fwd_valid", 64'(fwd_valid), 1);
      check("halt_fwd_data", fwd_data, 64'h55);
      step();
    end
    check("halt_retire_hold", retire_cnt, exp_retire - 1);
    halt = 1'b0;
    @(negedge clk);
    check("unhalt_rf_wen", 64'(rf_wen), 1);
    step();
    check("unhalt_retire_cnt", retire_cnt, exp_retire);
    check("unhalt_drained", 64'(fwd_valid), 0);

    // PC+4 back to back, including wrap to zero
    set_in(15, WB_PC4, 0, 0, 0, 0, 0, 64'h1000);                expect_wr(15, 64'h1004);
    step();
    check("b2b_wen0", 64'(rf_wen), 1);
    set_in(16, WB_PC4, 0, 0, 0, 0, 0, 64'h2000);                expect_wr(16, 64'h2004);
    step();
    check("b2b_wen1", 64'(rf_wen), 1);
    set_in(17, WB_PC4, 0, 0, 0, 0, 0, 64'hFFFF_FFFF_FFFF_FFFC); expect_wr(17, 64'h0);
    step();
    check("b2b_wen2", 64'(rf_wen), 1);
    set_in(18, WB_PC4, 0, 0, 0, 0, 0, 64'h8);                   expect_wr(18, 64'hC);
    step();
    check("b2b_wen3", 64'(rf_wen), 1);
    in_valid = 1'b0;
    step();
    check("b2b_retire_cnt", retire_cnt, exp_retire);

    // Reset while FULL discards the entry
    set_in(19, WB_ALU, 64'h77, 0, 0, 0, 0, 0);
    step();
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("rstfull_rf_wen", 64'(rf_wen), 0);
    check("rstfull_in_ready", 64'(in_ready), 0);
    step();
    rst = 1'b0;
    exp_retire = 0;
    @(negedge clk);
    check("rstfull_retire_cnt", retire_cnt, 0);
    check("rstfull_fwd_valid", 64'(fwd_valid), 0);
    check("rstfull_in_ready_after", 64'(in_ready), 1);
    check("rstfull_waddr", 64'(rf_waddr), 0);
    step();

    // Recovery after reset
    set_in(3, WB_ALU, 64'hABC, 0, 0, 0, 0, 0); expect_wr(3, 64'hABC);
    step();
    in_valid = 1'b0;
    step();
    check("recover_retire_cnt", retire_cnt, exp_retire);

    step();
    check("scoreboard_empty", 64'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ysyx_22040365_wbu.md
YSYX_22040365_WBU -- requirements
Module: ysyx_22040365_wbu

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 5, register-index width.
REQ-002 SHALL have parameter DATA_WIDTH, default 64, datapath width.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  upstream (EXU/LSU) result valid.
REQ-006 SHALL have port in_ready  output  1  WBU can accept a result this cycle.
REQ-007 SHALL have port in_rd  input  ADDR_WIDTH  destination register index.
REQ-008 SHALL have port in_rd_wen  input  1  instruction writes a register.
REQ-009 SHALL have port in_wb_sel  input  2  source select: 0 ALU, 1 LOAD, 2 PC4, 3 CSR.
REQ-010 SHALL have port in_alu_res, in_load_data, in_csr_data  input  DATA_WIDTH each  candidate results.
REQ-011 SHALL have port in_ld_size  input  2  0 byte, 1 half, 2 word, 3 dword; in_ld_unsigned  input  1  zero-extend.
REQ-012 SHALL have port in_pc  input  DATA_WIDTH  instruction PC.
REQ-013 SHALL have port halt  input  1  hold the buffered entry, no writeback.
REQ-014 SHALL have ports rf_wen  output  1, rf_waddr  output  ADDR_WIDTH, rf_wdata  output  DATA_WIDTH  regfile write port.
REQ-015 SHALL have ports fwd_valid  output  1, fwd_rd  output  ADDR_WIDTH, fwd_data  output  DATA_WIDTH  bypass to decode.
REQ-016 SHALL have port retire_cnt  output  64  retired-instruction count.

Function
REQ-017 SHALL hold one buffered entry (state EMPTY or FULL); handshake fires when in_valid && in_ready.
REQ-018 SHALL drive in_ready = EMPTY || (FULL && !halt); entry drains and refills in the same cycle.
REQ-019 SHALL compute final data at accept: ALU -> in_alu_res; LOAD -> extended load; PC4 -> in_pc+4 modulo 2^DATA_WIDTH; CSR -> in_csr_data.
REQ-020 SHALL extend loads from bit 0 of in_load_data: sign-extend size 0/1/2 unless in_ld_unsigned, zero-extend if set; size 3 passes unchanged.
REQ-021 SHALL assert rf_wen exactly one cycle after accept when FULL, !halt, buffered rd_wen=1, buffered rd!=0.
REQ-022 SHALL never write register 0; writes with rd=0 retire silently.
REQ-023 SHALL drive fwd_valid = FULL && rd_wen && rd!=0, with fwd_rd/fwd_data from the buffer, independent of halt.
REQ-024 SHALL increment retire_cnt by 1 on each cycle FULL && !halt, wrapping at 2^64.
REQ-025 SHALL return to EMPTY when the entry retires and no new accept occurs; stay FULL while halt.
REQ-026 SHALL keep rf_waddr/rf_wdata equal to buffered values whenever FULL; undefined value not permitted (zero when EMPTY).

Reset
REQ-027 SHALL, while rst=1 at an edge, enter EMPTY; rf_wen=0, fwd_valid=0, retire_cnt=0, buffered fields 0, in_ready=0 during reset cycle.
REQ-028 SHALL discard a FULL entry on reset without writing it.

Configuration
REQ-029 SHALL, when YSYX_22040365_DIFFTEST_EN is defined, add outputs commit_valid (1, = retire condition of REQ-024), commit_pc (DATA_WIDTH), commit_rd_wen (1), commit_rd, commit_data.
REQ-030 SHALL, without YSYX_22040365_DIFFTEST_EN, omit those ports and their registers; all other behaviour identical.

Structure
REQ-031 SHALL take wb_sel and ld_size encodings as typed constants from shared package ysyx_22040365_pkg.
REQ-032 SHALL place load extension in combinational sub-module ysyx_22040365_load_ext.

Verification
REQ-033 Reset then ALU result 0x1234, rd=5 -> next cycle rf_wen=1, waddr=5, wdata=0x1234, retire_cnt=1.
REQ-034 LOAD byte 0x80, signed -> wdata=0xFFFFFFFFFFFFFF80; unsigned -> 0x80; word 0x80000000 signed -> 0xFFFFFFFF80000000.
REQ-035 rd=0, wb_sel=ALU, 0xDEAD -> rf_wen=0, fwd_valid=0, retire_cnt increments.
REQ-036 halt=1 for 3 cycles while FULL -> in_ready=0, rf_wen=0, fwd_valid=1; halt release -> one write, counter +1.
REQ-037 Back-to-back valid for 4 cycles, PC4 with pc=0xFFFFFFFFFFFFFFFC -> one write per cycle, wdata=0 for wrap case.
REQ-038 rst asserted while FULL -> no write, retire_cnt=0, EMPTY next cycle.
